rpn_stack_ctrl: RTL and testbench
=================================

RPN_STACK_CTRL -- requirements
Module: rpn_stack_ctrl

Interface
REQ-001 SHALL have parameter N, default 16: operand/result width in bits, signed two's complement.
REQ-002 SHALL have parameter DEPTH, default 8: maximum stack depth, including the top-of-stack register.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clear  input  1  synchronous stack clear; highest priority after rst.
REQ-006 SHALL have port push_valid  input  1  push request.
REQ-007 SHALL have port push_data  input  N  operand to push.
REQ-008 SHALL have port op_valid  input  1  operation request.
REQ-009 SHALL have port op_cmd  input  `AC_N  ALU command code (`AC_AD/`AC_SB/`AC_MU/`AC_DI).
REQ-010 SHALL have port ready  output  1  high only in IDLE; a request is accepted on valid&&ready.
REQ-011 SHALL have port top  output  N  current top-of-stack value.
REQ-012 SHALL have port depth  output  clog2(DEPTH+1)  number of stacked entries.
REQ-013 SHALL have port err  output  3  status of the last accepted request (codes in REQ-031).
REQ-014 SHALL have port alu_a, alu_b  output  N each  ALU operands (second-from-top, top).
REQ-015 SHALL have port alu_cmd  output  `AC_N  ALU command.
REQ-016 SHALL have port alu_c  input  N  ALU combinational result.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD -> EXEC -> IDLE; push completes in IDLE.
REQ-018 Push, accepted in IDLE with depth<DEPTH: next edge, mem[depth-1] <= top if depth>0; top <= push_data; depth += 1; err <= OK.
REQ-019 Push with depth==DEPTH: stack unchanged; err <= OVERFLOW.
REQ-020 Simultaneous op_valid and push_valid in IDLE: op accepted; push not accepted; requester holds push_valid.
REQ-021 Op, accepted with depth>=2 and valid cmd: IDLE->LOAD, latching cmd. LOAD reads mem[depth-2] into operand register A. EXEC drives alu_a=A, alu_b=top, alu_cmd=cmd.
REQ-022 EXEC outcome: top <= alu_c; depth -= 1; err <= OK; return to IDLE. ready reasserts 3 cycles after acceptance.
REQ-023 Op with depth<2: no state change beyond err <= UNDERFLOW; stay IDLE.
REQ-024 Op with cmd not in the four codes: err <= BADOP; stay IDLE.
REQ-025 `AC_DI with top==0, detected in EXEC: stack unchanged; err <= DIV0; return to IDLE.
REQ-026 Arithmetic SHALL be as the alu block defines: N-bit wraparound for add/sub; low N bits for multiply; signed divide truncates toward zero; no overflow flag.
REQ-027 Outside EXEC, alu_a, alu_b and alu_cmd SHALL hold their last values (no X propagation).
REQ-028 clear in any state: next edge state=IDLE, depth=0, top=0, err=OK; an in-flight op is aborted with no write.
REQ-029 ready SHALL be combinational from state only, with no dependence on valid inputs.

Reset
REQ-030 While rst is high: state=IDLE, top=0, depth=0, err=OK, A=0, alu_cmd=`AC_AD; ready=1 after release. Memory contents are don't-care.

Structure
REQ-031 The shared include (ALU_INTERFACE.v) SHALL hold err codes OK=0, OVERFLOW=1, UNDERFLOW=2, DIV0=3, BADOP=4, plus the FSM state encodings, next to the `AC_* codes.
REQ-032 Storage below the top entry SHALL be sub-module rpn_stack_mem: DEPTH-1 words, 1 synchronous write port, 1 registered read port, no reset.
REQ-033 The alu block SHALL NOT be instantiated inside this block; the parent wires alu_a, alu_b, alu_cmd and alu_c.

Verification
REQ-034 push 7, push 5, op `AC_SB -> top=2, depth=1, err=OK; ready low for exactly 2 cycles after acceptance.
REQ-035 push -6, push 4, op `AC_DI -> top=-1, depth=1; then push 300, op `AC_MU (N=16) -> top=-300 (0xFED4).
REQ-036 push 3, op `AC_AD -> err=UNDERFLOW, top=3, depth=1; push 9, push 0, op `AC_DI -> err=DIV0, top=0, depth=3.
REQ-037 9 pushes with DEPTH=8 -> 9th gives err=OVERFLOW, depth=8; then 7 `AC_AD ops -> sum of the first 8 pushes, depth=1.
REQ-038 push_valid and op_valid both high with depth=2 -> op executes, push is taken after ready returns, depth ends 2.
REQ-039 rst pulse in LOAD, and separately clear in EXEC -> depth=0, top=0, err=OK, no result written; ready high on the next cycle.

Source files
------------

// File: rtl/rpn_stack_ctrl_pkg.sv
// Shared RPN controller codes: ALU command codes, status codes and FSM encodings (ALU_INTERFACE).
// Pure definitions with no latency or flow control; the package wraps the raw codes in types.
`ifndef ALU_INTERFACE_DEFS
`define ALU_INTERFACE_DEFS
`define AC_N     3
`define AC_AD    3'd0
`define AC_SB    3'd1
`define AC_MU    3'd2
`define AC_DI    3'd3
`define ERR_OK        3'd0
`define ERR_OVERFLOW  3'd1
`define ERR_UNDERFLOW 3'd2
`define ERR_DIV0      3'd3
`define ERR_BADOP     3'd4
`define ST_IDLE  2'd0
`define ST_LOAD  2'd1
`define ST_EXEC  2'd2
`endif

package rpn_stack_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `ST_IDLE,
        ST_LOAD = `ST_LOAD,
        ST_EXEC = `ST_EXEC
    } state_t;

    typedef enum logic [2:0] {
        E_OK        = `ERR_OK,
        E_OVERFLOW  = `ERR_OVERFLOW,
        E_UNDERFLOW = `ERR_UNDERFLOW,
        E_DIV0      = `ERR_DIV0,
        E_BADOP     = `ERR_BADOP
    } err_t;

    function automatic logic cmd_known(input logic [`AC_N-1:0] c);
        case (c)
            `AC_AD, `AC_SB, `AC_MU, `AC_DI: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rpn_stack_mem.sv
// Stack storage below top-of-stack: one sync write port, one registered read port, no reset.
// Read data appears the cycle after rd_en; no backpressure, caller sequences accesses.
module rpn_stack_mem #(
    parameter int N     = 16,
    parameter int WORDS = 7,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_data
);

    logic [N-1:0] mem_q [WORDS];
    logic [N-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN stack controller: push completes in one cycle; ops take IDLE->LOAD->EXEC, ready back 3 cycles later.
// Backpressure: ready is high only in IDLE; op wins over a simultaneous push, which must be held.
module rpn_stack_ctrl
    import rpn_stack_ctrl_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push_valid,
    input  logic [N-1:0]                 push_data,
    input  logic                         op_valid,
    input  logic [`AC_N-1:0]             op_cmd,
    output logic                         ready,
    output logic [N-1:0]                 top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic [2:0]                   err,
    output logic [N-1:0]                 alu_a,
    output logic [N-1:0]                 alu_b,
    output logic [`AC_N-1:0]             alu_cmd,
    input  logic [N-1:0]                 alu_c
);

    localparam int DW    = $clog2(DEPTH+1);
    localparam int WORDS = DEPTH - 1;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t             state_q, state_d;
    err_t               err_q, err_d;
    logic [N-1:0]       top_q, top_d;
    logic [DW-1:0]      depth_q, depth_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic [`AC_N-1:0]   cmd_q, cmd_d;
    logic [`AC_N-1:0]   alu_cmd_q, alu_cmd_d;

    logic               wr_en, rd_en;
    logic [AW-1:0]      wr_addr, rd_addr;
    logic [N-1:0]       rd_data;

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        top_d     = top_q;
        depth_d   = depth_q;
        a_d       = a_q;
        b_d       = b_q;
        cmd_d     = cmd_q;
        alu_cmd_d = alu_cmd_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        wr_addr   = AW'(depth_q - DW'(1));
        rd_addr   = AW'(depth_q - DW'(2));

        unique case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    if (!cmd_known(op_cmd)) begin
                        err_d = E_BADOP;
                    end else if (depth_q < DW'(2)) begin
                        err_d = E_UNDERFLOW;
                    end else begin
                        // Second-from-top is fetched now so it is on rd_data during LOAD.
                        cmd_d   = op_cmd;
                        rd_en   = 1'b1;
                        state_d = ST_LOAD;
                    end
                end else if (push_valid) begin
                    if (depth_q == DW'(DEPTH)) begin
                        err_d = E_OVERFLOW;
                    end else begin
                        wr_en   = (depth_q != '0);
                        top_d   = push_data;
                        depth_d = depth_q + DW'(1);
                        err_d   = E_OK;
                    end
                end
            end
            ST_LOAD: begin
                a_d       = rd_data;
                b_d       = top_q;
                alu_cmd_d = cmd_q;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                if (alu_cmd_q == `AC_DI && b_q == '0) begin
                    err_d = E_DIV0;
                end else begin
                    top_d   = alu_c;
                    depth_d = depth_q - DW'(1);
                    err_d   = E_OK;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear) begin
            state_d = ST_IDLE;
            depth_d = '0;
            top_d   = '0;
            err_d   = E_OK;
            wr_en   = 1'b0;
            rd_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            err_q     <= E_OK;
            top_q     <= '0;
            depth_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cmd_q     <= `AC_AD;
            alu_cmd_q <= `AC_AD;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            top_q     <= top_d;
            depth_q   <= depth_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cmd_q     <= cmd_d;
            alu_cmd_q <= alu_cmd_d;
        end
    end

    rpn_stack_mem #(
        .N     (N),
        .WORDS (WORDS),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (top_q),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign ready   = (state_q == ST_IDLE);
    assign top     = top_q;
    assign depth   = depth_q;
    assign err     = err_q;
    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_cmd = alu_cmd_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Directed bench for rpn_stack_ctrl with a behavioural ALU wired in place of the parent's alu block.
module tb_rpn_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        push_valid;
    logic [15:0] push_data;
    logic        op_valid;
    logic [2:0]  op_cmd;
    logic        ready;
    logic [15:0] top;
    logic [3:0]  depth;
    logic [2:0]  err;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_cmd;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    rpn_stack_ctrl #(.N(16), .DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .push_valid (push_valid),
        .push_data  (push_data),
        .op_valid   (op_valid),
        .op_cmd     (op_cmd),
        .ready      (ready),
        .top        (top),
        .depth      (depth),
        .err        (err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cmd    (alu_cmd),
        .alu_c      (alu_c)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_c = '0;
        case (alu_cmd)
            `AC_AD: alu_c = alu_a + alu_b;
            `AC_SB: alu_c = alu_a - alu_b;
            `AC_MU: alu_c = alu_a * alu_b;
            `AC_DI: if (alu_b != '0) alu_c = $signed(alu_a) / $signed(alu_b);
            default: alu_c = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        push_valid = 1'b1;
        push_data  = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 10) begin
            tick();
            cycles++;
        end
        if (cycles >= 10) chk("ready_timeout", 32'(cycles), 32'd2);
    endtask

    task automatic do_op(input logic [2:0] c, output int cycles);
        op_valid = 1'b1;
        op_cmd   = c;
        tick();
        op_valid = 1'b0;
        wait_ready(cycles);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [15:0] t, input logic [3:0] d, input logic [2:0] e);
        chk({tag, "_top"},   32'(top),   32'(t));
        chk({tag, "_depth"}, 32'(depth), 32'(d));
        chk({tag, "_err"},   32'(err),   32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0;
        push_valid = 1'b0; push_data = '0;
        op_valid = 1'b0; op_cmd = `AC_AD;
        tick(); tick();
        chk_state("reset", 16'h0000, 4'd0, `ERR_OK);
        chk("reset_alu_a",   32'(alu_a),   32'h0);
        chk("reset_alu_cmd", 32'(alu_cmd), 32'(`AC_AD));
        rst = 1'b0;
        tick();
        chk("reset_ready", 32'(ready), 32'h1);

        // 7 - 5, ready low for exactly two cycles
        push(16'd7); push(16'd5);
        do_op(`AC_SB, lat);
        chk("sub_lat", 32'(lat), 32'd2);
        chk_state("sub", 16'd2, 4'd1, `ERR_OK);
        chk("hold_alu_a",   32'(alu_a),   32'd7);
        chk("hold_alu_b",   32'(alu_b),   32'd5);
        chk("hold_alu_cmd", 32'(alu_cmd), 32'(`AC_SB));
        do_clear();
        chk_state("clear_idle", 16'h0000, 4'd0, `ERR_OK);

        // -6 / 4 truncates to -1; then -1 * 300 = -300
        push(16'hFFFA); push(16'd4);
        do_op(`AC_DI, lat);
        chk_state("div", 16'hFFFF, 4'd1, `ERR_OK);
        push(16'd300);
        do_op(`AC_MU, lat);
        chk_state("mul", 16'hFED4, 4'd1, `ERR_OK);
        do_clear();

        // underflow, divide by zero, bad opcode
        push(16'd3);
        do_op(`AC_AD, lat);
        chk("underflow_lat", 32'(lat), 32'd0);
        chk_state("underflow", 16'd3, 4'd1, `ERR_UNDERFLOW);
        push(16'd9); push(16'd0);
        do_op(`AC_DI, lat);
        chk_state("div0", 16'd0, 4'd3, `ERR_DIV0);
        do_op(3'd7, lat);
        chk_state("badop", 16'd0, 4'd3, `ERR_BADOP);
        do_op(3'd5, lat);
        chk("badop5_err", 32'(err), 32'(`ERR_BADOP));
        do_clear();

        // fill to capacity, overflow, then fold with adds
        for (int i = 1; i <= 9; i++) push(16'(i));
        chk_state("overflow", 16'd8, 4'd8, `ERR_OVERFLOW);
        for (int i = 0; i < 7; i++) do_op(`AC_AD, lat);
        chk_state("fold_sum", 16'd36, 4'd1, `ERR_OK);
        do_clear();

        // op wins over simultaneous push; push lands once ready returns
        push(16'd10); push(16'd3);
        push_valid = 1'b1; push_data = 16'd20;
        op_valid = 1'b1; op_cmd = `AC_AD;
        tick();
        op_valid = 1'b0;
        chk("collide_ready", 32'(ready), 32'h0);
        chk("collide_depth", 32'(depth), 32'd2);
        wait_ready(lat);
        chk("collide_mid_depth", 32'(depth), 32'd1);
        tick();
        push_valid = 1'b0;
        chk_state("collide", 16'd20, 4'd2, `ERR_OK);
        do_op(`AC_SB, lat);
        chk_state("collide_sub", 16'hFFF9, 4'd1, `ERR_OK);
        do_clear();

        // async reset while in LOAD
        push(16'd5); push(16'd6);
        do_op(3'd6, lat);
        op_valid = 1'b1; op_cmd = `AC_AD;
        tick();
        op_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_load_ready", 32'(ready), 32'h1);
        tick();
        rst = 1'b0;
        tick();
        chk_state("rst_load", 16'h0000, 4'd0, `ERR_OK);
        chk("rst_load_ready2", 32'(ready), 32'h1);
        tick();
        chk("rst_load_nowrite", 32'(top), 32'h0);

        // clear while in EXEC
        push(16'd5); push(16'd6);
        do_op(3'd7, lat);
        op_valid = 1'b1; op_cmd = `AC_MU;
        tick();
        op_valid = 1'b0;
        tick();
        chk("exec_reached", 32'(ready), 32'h0);
        do_clear();
        chk_state("clear_exec", 16'h0000, 4'd0, `ERR_OK);
        chk("clear_exec_ready", 32'(ready), 32'h1);
        tick();
        chk("clear_exec_nowrite", 32'(top), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
